// File: rtl/inst_encoder.sv
// inst_encoder: streaming RISC-V instruction encoder, the inverse of the core's
// immediate generator. It takes decoded fields and a full 32-bit immediate,
// range-checks the immediate for the chosen format and packs the instruction
// word. Each word is emitted with an instruction-memory write address.
// Encode errors substitute a NOP and are recorded in sticky/counter status.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   input handshake for in_fmt/opcode/funct3/rd/rs1/rs2/imm
//   out_valid/out_ready output handshake for out_ins/out_addr/out_err
//   clr_err             clears err_sticky and err_cnt
//   err_sticky, err_cnt error since reset/clear, saturating error count
//   rt_mismatch, rt_fail  (only with INST_ENCODER_ROUNDTRIP_EN) re-extraction check
//
// Optional feature macro: INST_ENCODER_ROUNDTRIP_EN

`ifndef Ext_ImmI
`define Ext_ImmI 3'b000
`endif
`ifndef Ext_ImmS
`define Ext_ImmS 3'b001
`endif
`ifndef Ext_ImmB
`define Ext_ImmB 3'b010
`endif
`ifndef Ext_ImmU
`define Ext_ImmU 3'b011
`endif
`ifndef Ext_ImmJ
`define Ext_ImmJ 3'b100
`endif

module inst_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ins,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    input  logic              clr_err,
    output logic              err_sticky,
    output logic [7:0]        err_cnt
`ifdef INST_ENCODER_ROUNDTRIP_EN
    ,
    output logic              rt_mismatch,
    output logic              rt_fail
`endif
);

    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    // Stage 1 registers
    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [6:0]  s1_opcode;
    logic [2:0]  s1_funct3;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;

    logic        s2_adv;
    logic        s1_move;
    logic        enc_err;
    logic [31:0] enc_raw;
    logic [31:0] enc_ins;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign s1_move  = s1_valid && s2_adv;

    // Stage 1: capture the input fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= '0;
            s1_opcode <= '0;
            s1_funct3 <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_imm    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= in_fmt;
                s1_opcode <= in_opcode;
                s1_funct3 <= in_funct3;
                s1_rd     <= in_rd;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_imm    <= in_imm;
            end
        end
    end

    // Range check and scatter of the immediate into instruction bits
    always_comb begin
        enc_err = 1'b0;
        enc_raw = '0;
        case (s1_fmt)
            `Ext_ImmI: begin
                enc_err = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
                enc_raw = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            end
            `Ext_ImmS: begin
                enc_err = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
                enc_raw = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            end
            `Ext_ImmB: begin
                enc_err = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
                enc_raw = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                           s1_imm[4:1], s1_imm[11], s1_opcode};
            end
            `Ext_ImmU: begin
                enc_err = |s1_imm[11:0];
                enc_raw = {s1_imm[31:12], s1_rd, s1_opcode};
            end
            `Ext_ImmJ: begin
                enc_err = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
                enc_raw = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                           s1_rd, s1_opcode};
            end
            default: begin
                enc_err = 1'b1;
                enc_raw = '0;
            end
        endcase
        enc_ins = enc_err ? NOP_INS : enc_raw;
    end

    // Stage 2: output word, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ins   <= '0;
            out_err   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_ins <= enc_ins;
                out_err <= enc_err;
            end
        end
    end

    // Write address advances on every accepted output word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_addr <= ADDR_W'(BASE_ADDR);
        end else if (out_valid && out_ready) begin
            out_addr <= out_addr + ADDR_W'(ADDR_STEP);
        end
    end

    // Error accounting as a word enters stage 2; a clear that coincides with a
    // new error leaves exactly that one error recorded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (clr_err) begin
            err_sticky <= s1_move && enc_err;
            err_cnt    <= (s1_move && enc_err) ? 8'd1 : 8'd0;
        end else if (s1_move && enc_err) begin
            err_sticky <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

`ifdef INST_ENCODER_ROUNDTRIP_EN
    logic [31:0] rt_imm;
    logic        rt_bad;

    // Re-extract the immediate as the core's immediate generator would
    always_comb begin
        rt_imm = '0;
        case (s1_fmt)
            `Ext_ImmI: rt_imm = {{20{enc_ins[31]}}, enc_ins[31:20]};
            `Ext_ImmS: rt_imm = {{20{enc_ins[31]}}, enc_ins[31:25], enc_ins[11:7]};
            `Ext_ImmB: rt_imm = {{20{enc_ins[31]}}, enc_ins[7], enc_ins[30:25],
                                 enc_ins[11:8], 1'b0};
            `Ext_ImmU: rt_imm = {enc_ins[31:12], 12'b0};
            `Ext_ImmJ: rt_imm = {{12{enc_ins[31]}}, enc_ins[19:12], enc_ins[20],
                                 enc_ins[30:21], 1'b0};
            default:   rt_imm = '0;
        endcase
        rt_bad = s1_move && !enc_err && (rt_imm != s1_imm);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rt_mismatch <= 1'b0;
            rt_fail     <= 1'b0;
        end else begin
            if (s2_adv) begin
                rt_mismatch <= rt_bad;
            end
            if (clr_err) begin
                rt_fail <= rt_bad;
            end else if (rt_bad) begin
                rt_fail <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (default build).

`ifndef Ext_ImmI
`define Ext_ImmI 3'b000
`endif
`ifndef Ext_ImmS
`define Ext_ImmS 3'b001
`endif
`ifndef Ext_ImmB
`define Ext_ImmB 3'b010
`endif
`ifndef Ext_ImmU
`define Ext_ImmU 3'b011
`endif
`ifndef Ext_ImmJ
`define Ext_ImmJ 3'b100
`endif

module tb_inst_encoder;

    localparam logic [2:0] FMT_I   = `Ext_ImmI;
    localparam logic [2:0] FMT_S   = `Ext_ImmS;
    localparam logic [2:0] FMT_B   = `Ext_ImmB;
    localparam logic [2:0] FMT_U   = `Ext_ImmU;
    localparam logic [2:0] FMT_J   = `Ext_ImmJ;
    localparam logic [2:0] FMT_BAD = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [9:0]  out_addr;
    logic        out_err;
    logic        clr_err;
    logic        err_sticky;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    inst_encoder #(
        .ADDR_W   (10),
        .BASE_ADDR(0),
        .ADDR_STEP(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ins   (out_ins),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .clr_err   (clr_err),
        .err_sticky(err_sticky),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        in_valid  = 1'b1;
        in_fmt    = f;
        in_opcode = op;
        in_funct3 = f3;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    task automatic idle;
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_fmt    = '0;
        in_opcode = '0;
        in_funct3 = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ins", out_ins, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;

        // addi x1, x0, 5 with two-edge latency
        drive(FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        chk("i_in_ready", 32'(in_ready), 32'd1);
        tick();
        idle();
        chk("i_lat_one_edge", 32'(out_valid), 32'd0);
        tick();
        chk("i_out_valid", 32'(out_valid), 32'd1);
        chk("i_ins", out_ins, 32'h0050_0093);
        chk("i_addr", 32'(out_addr), 32'd0);
        chk("i_err", 32'(out_err), 32'd0);
        tick();

        // sw then beq back-to-back
        drive(FMT_S, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8);
        tick();
        drive(FMT_B, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
        tick();
        idle();
        chk("sw_ins", out_ins, 32'h0020_A423);
        chk("sw_addr", 32'(out_addr), 32'd4);
        tick();
        chk("beq_ins", out_ins, 32'hFE00_0EE3);
        chk("beq_addr", 32'(out_addr), 32'd8);
        tick();

        // lui then jal
        drive(FMT_U, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        tick();
        drive(FMT_J, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        tick();
        idle();
        chk("lui_ins", out_ins, 32'h1234_52B7);
        chk("lui_addr", 32'(out_addr), 32'd12);
        tick();
        chk("jal_ins", out_ins, 32'h0010_00EF);
        chk("jal_addr", 32'(out_addr), 32'd16);
        tick();

        // I immediate out of range
        drive(FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        tick();
        idle();
        tick();
        chk("ierr_ins", out_ins, 32'h0000_0013);
        chk("ierr_err", 32'(out_err), 32'd1);
        chk("ierr_sticky", 32'(err_sticky), 32'd1);
        chk("ierr_cnt", 32'(err_cnt), 32'd1);
        chk("ierr_addr", 32'(out_addr), 32'd20);
        tick();

        // B imm=6 is legal
        drive(FMT_B, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd6);
        tick();
        idle();
        tick();
        chk("b6_ins", out_ins, 32'h0000_0363);
        chk("b6_err", 32'(out_err), 32'd0);
        chk("b6_cnt", 32'(err_cnt), 32'd1);
        tick();

        // B imm=3 is odd
        drive(FMT_B, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        tick();
        idle();
        tick();
        chk("b3_ins", out_ins, 32'h0000_0013);
        chk("b3_err", 32'(out_err), 32'd1);
        chk("b3_cnt", 32'(err_cnt), 32'd2);
        tick();

        // clear
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_sticky", 32'(err_sticky), 32'd0);
        chk("clr_cnt", 32'(err_cnt), 32'd0);

        // clear coinciding with an illegal-format error
        drive(FMT_BAD, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        tick();
        idle();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clrnew_err", 32'(out_err), 32'd1);
        chk("clrnew_sticky", 32'(err_sticky), 32'd1);
        chk("clrnew_cnt", 32'(err_cnt), 32'd1);
        chk("clrnew_addr", 32'(out_addr), 32'd32);
        tick();

        // Backpressure from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("bp_addr_base", 32'(out_addr), 32'd0);
        out_ready = 1'b0;
        drive(FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        tick();
        drive(FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2);
        tick();
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        drive(FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        tick();
        tick();
        chk("bp_in_ready_held", 32'(in_ready), 32'd0);
        chk("bp_w0_stable", out_ins, 32'h0010_0093);
        chk("bp_w0_addr", 32'(out_addr), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 32'(in_ready), 32'd1);
        tick();
        idle();
        chk("bp_w1_ins", out_ins, 32'h0020_0093);
        chk("bp_w1_addr", 32'(out_addr), 32'd4);
        tick();
        chk("bp_w2_ins", out_ins, 32'h0030_0093);
        chk("bp_w2_addr", 32'(out_addr), 32'd8);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_end_addr", 32'(out_addr), 32'd12);

        // Reset with both stages full
        out_ready = 1'b0;
        drive(FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd9);
        tick();
        drive(FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd10);
        tick();
        idle();
        chk("mid_full", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_addr", 32'(out_addr), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("mid_no_leftover", 32'(out_valid), 32'd0);
        drive(FMT_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd7);
        tick();
        idle();
        chk("post_lat", 32'(out_valid), 32'd0);
        tick();
        chk("post_ins", out_ins, 32'h0070_0093);
        chk("post_addr", 32'(out_addr), 32'd0);
        tick();
        chk("post_drained", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
